// File: rtl/hex_scroll_marquee_if.sv
// Control, message-write and display signals of the scrolling marquee.
// The master modport drives controls and writes; the slave modport is the marquee itself.
interface hex_scroll_marquee_if #(
  parameter int NUM_DIGITS = 4,
  parameter int MSG_LEN    = 8
);
  localparam int POS_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;

  logic                    run;
  logic                    dir;
  logic                    step;
  logic                    wr_en;
  logic [4:0]              wr_addr;
  logic [4:0]              wr_data;
  logic [NUM_DIGITS*7-1:0] hex;
  logic [POS_W-1:0]        pos;
  logic                    wrap;

  modport master (
    output run, dir, step, wr_en, wr_addr, wr_data,
    input  hex, pos, wrap
  );

  modport slave (
    input  run, dir, step, wr_en, wr_addr, wr_data,
    output hex, pos, wrap
  );
endinterface

// File: rtl/hex_scroll_marquee.sv
// Scrolling-message driver for a bank of active-low seven-segment digits.
// A writable glyph message is windowed by pos, which steps on a prescaled tick or a manual pulse.
module hex_scroll_marquee #(
  parameter int NUM_DIGITS = 4,
  parameter int MSG_LEN    = 8,
  parameter int TICK_DIV   = 50000000
) (
  input logic                 clk,
  input logic                 rst,
  hex_scroll_marquee_if.slave bus
);

  localparam int               POS_W       = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam int               CNT_W       = $clog2(TICK_DIV);
  localparam logic [POS_W-1:0] POS_MAX     = POS_W'(MSG_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(TICK_DIV - 1);
  localparam logic [4:0]       GLYPH_BLANK = 5'h10;

  // Segment order {g,f,e,d,c,b,a}, active low.
  function automatic logic [6:0] glyph_to_seg(input logic [4:0] glyph);
    logic [6:0] seg;
    case (glyph)
      5'h00:   seg = 7'b1000000;
      5'h01:   seg = 7'b1111001;
      5'h02:   seg = 7'b0100100;
      5'h03:   seg = 7'b0110000;
      5'h04:   seg = 7'b0011001;
      5'h05:   seg = 7'b0010010;
      5'h06:   seg = 7'b0000010;
      5'h07:   seg = 7'b1111000;
      5'h08:   seg = 7'b0000000;
      5'h09:   seg = 7'b0010000;
      5'h0A:   seg = 7'b0001000;
      5'h0B:   seg = 7'b0000011;
      5'h0C:   seg = 7'b1000110;
      5'h0D:   seg = 7'b0100001;
      5'h0E:   seg = 7'b0000110;
      5'h0F:   seg = 7'b0001110;
      5'h11:   seg = 7'b0111111;
      5'h12:   seg = 7'b0101111;
      5'h13:   seg = 7'b0101011;
      5'h14:   seg = 7'b0100011;
      5'h15:   seg = 7'b0001100;
      5'h16:   seg = 7'b1000111;
      5'h17:   seg = 7'b0001001;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [POS_W-1:0]        pos_q, pos_d;
  logic                    wrap_q, wrap_d;
  logic [4:0]              msg_q [MSG_LEN];
  logic [4:0]              msg_d [MSG_LEN];
  logic [NUM_DIGITS*7-1:0] hex_q, hex_d;
  logic                    tick;
  logic                    adv;
  logic [5:0]              win_idx   [NUM_DIGITS];
  logic [4:0]              win_glyph [NUM_DIGITS];

  // Prescaler is parked at zero while paused so a resume waits a full period.
  always_comb begin
    tick   = bus.run && (cnt_q == CNT_MAX);
    adv    = bus.run ? tick : bus.step;
    cnt_d  = (bus.run && !tick) ? cnt_q + 1'b1 : '0;
    pos_d  = pos_q;
    wrap_d = 1'b0;
    if (adv) begin
      if (bus.dir) begin
        if (pos_q == '0) begin
          pos_d  = POS_MAX;
          wrap_d = 1'b1;
        end else begin
          pos_d  = pos_q - 1'b1;
        end
      end else begin
        if (pos_q == POS_MAX) begin
          pos_d  = '0;
          wrap_d = 1'b1;
        end else begin
          pos_d  = pos_q + 1'b1;
        end
      end
    end
  end

  // Out-of-range addresses match no entry, so those writes fall away.
  always_comb begin
    msg_d = msg_q;
    for (int i = 0; i < MSG_LEN; i++) begin
      if (bus.wr_en && (bus.wr_addr == 5'(i))) msg_d[i] = bus.wr_data;
    end
  end

  // Digit k shows msg[(pos + NUM_DIGITS-1-k) mod MSG_LEN]; the sum is below 2*MSG_LEN.
  always_comb begin
    hex_d = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      win_idx[k] = 6'(pos_q) + 6'(NUM_DIGITS - 1 - k);
      if (win_idx[k] >= 6'(MSG_LEN)) win_idx[k] = win_idx[k] - 6'(MSG_LEN);
      win_glyph[k] = GLYPH_BLANK;
      for (int i = 0; i < MSG_LEN; i++) begin
        if (win_idx[k] == 6'(i)) win_glyph[k] = msg_q[i];
      end
      hex_d[7*k +: 7] = glyph_to_seg(win_glyph[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      pos_q  <= '0;
      wrap_q <= 1'b0;
      hex_q  <= '1;
      for (int i = 0; i < MSG_LEN; i++) msg_q[i] <= GLYPH_BLANK;
    end else begin
      cnt_q  <= cnt_d;
      pos_q  <= pos_d;
      wrap_q <= wrap_d;
      hex_q  <= hex_d;
      msg_q  <= msg_d;
    end
  end

  assign bus.hex  = hex_q;
  assign bus.pos  = pos_q;
  assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_hex_scroll_marquee.sv
// Bench for hex_scroll_marquee: vector table, directed multi-cycle sequences,
// then randomized traffic compared against a glyph-window reference model.
module tb_hex_scroll_marquee;

  localparam int ND = 4;
  localparam int ML = 8;
  localparam int TD = 4;

  localparam logic [6:0] S_BL = 7'b1111111;
  localparam logic [6:0] S_MI = 7'b0111111;
  localparam logic [6:0] S_0  = 7'b1000000;
  localparam logic [6:0] S_1  = 7'b1111001;
  localparam logic [6:0] S_E  = 7'b0000110;
  localparam logic [6:0] S_D  = 7'b0100001;
  localparam logic [27:0] H_ALL = 28'hFFFFFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hex_scroll_marquee_if #(.NUM_DIGITS(ND), .MSG_LEN(ML)) bus ();

  hex_scroll_marquee #(.NUM_DIGITS(ND), .MSG_LEN(ML), .TICK_DIV(TD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [6:0]  seg_lut [32];
  logic [4:0]  m_msg [ML];
  int          m_pos;
  int          m_cnt;
  logic        m_wrap;
  logic [27:0] m_hex;

  typedef struct {
    logic        rst, run, dir, step, wr_en;
    logic [4:0]  wr_addr, wr_data;
    logic [2:0]  exp_pos;
    logic        exp_wrap;
    logic [27:0] exp_hex;
  } vec_t;
  vec_t tbl [7];

  function automatic logic [27:0] hx(input logic [6:0] d3, input logic [6:0] d2,
                                     input logic [6:0] d1, input logic [6:0] d0);
    return {d3, d2, d1, d0};
  endfunction

  function automatic logic [27:0] render();
    logic [27:0] r;
    r = '1;
    for (int k = 0; k < ND; k++) r[7*k +: 7] = seg_lut[m_msg[(m_pos + ND - 1 - k) % ML]];
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Advance the model with the inputs now applied, then clock the DUT.
  task automatic step_clk();
    logic [27:0] nh;
    logic        tick, adv;
    nh = render();
    if (rst) begin
      m_pos = 0; m_cnt = 0; m_wrap = 1'b0; m_hex = H_ALL;
      for (int i = 0; i < ML; i++) m_msg[i] = 5'h10;
    end else begin
      tick  = bus.run && (m_cnt == TD - 1);
      adv   = bus.run ? tick : bus.step;
      m_cnt = (bus.run && !tick) ? m_cnt + 1 : 0;
      m_wrap = 1'b0;
      if (adv) begin
        m_pos  = (m_pos + (bus.dir ? ML - 1 : 1)) % ML;
        m_wrap = bus.dir ? (m_pos == ML - 1) : (m_pos == 0);
      end
      if (bus.wr_en && bus.wr_addr < ML) m_msg[bus.wr_addr] = bus.wr_data;
      m_hex = nh;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic r, input logic run, input logic dir, input logic stp,
                        input logic we, input logic [4:0] wa, input logic [4:0] wd);
    rst = r; bus.run = run; bus.dir = dir; bus.step = stp;
    bus.wr_en = we; bus.wr_addr = wa; bus.wr_data = wd;
  endtask

  initial begin
    int nwrap;
    logic changed;
    seg_lut = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110,
                7'b1111111, 7'b0111111, 7'b0101111, 7'b0101011,
                7'b0100011, 7'b0001100, 7'b1000111, 7'b0001001,
                7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111,
                7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111};
    m_pos = 0; m_cnt = 0; m_wrap = 1'b0; m_hex = H_ALL;
    for (int i = 0; i < ML; i++) m_msg[i] = 5'h10;

    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'h00, 3'd0, 1'b0, H_ALL};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'h0D, 3'd0, 1'b0, H_ALL};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 5'h0E, 3'd0, 1'b0, hx(S_D, S_BL, S_BL, S_BL)};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd2, 5'h01, 3'd0, 1'b0, hx(S_D, S_E, S_BL, S_BL)};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 5'h00, 3'd0, 1'b0, hx(S_D, S_E, S_1, S_BL)};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 5'h00, 3'd0, 1'b0, hx(S_D, S_E, S_1, S_0)};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'h00, 3'd0, 1'b0, hx(S_D, S_E, S_1, S_0)};

    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
    step_clk();
    for (int v = 0; v < 7; v++) begin
      set_in(tbl[v].rst, tbl[v].run, tbl[v].dir, tbl[v].step,
             tbl[v].wr_en, tbl[v].wr_addr, tbl[v].wr_data);
      step_clk();
      chk($sformatf("tbl%0d_pos", v), bus.pos, tbl[v].exp_pos);
      chk($sformatf("tbl%0d_wrap", v), bus.wrap, tbl[v].exp_wrap);
      chk($sformatf("tbl%0d_hex", v), bus.hex, tbl[v].exp_hex);
    end

    // Auto-scroll left through a full revolution
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
    nwrap = 0;
    for (int c = 1; c <= 32; c++) begin
      step_clk();
      if (bus.wrap) nwrap++;
      if (c == 3)  chk("left_pos_before_tick", bus.pos, 0);
      if (c == 4)  chk("left_pos1", bus.pos, 1);
      if (c == 5)  chk("left_hex_pos1", bus.hex, hx(S_E, S_1, S_0, S_BL));
      if (c == 20) chk("left_pos5", bus.pos, 5);
      if (c == 21) chk("left_hex_pos5", bus.hex, hx(S_BL, S_BL, S_BL, S_D));
      if (c == 32) begin
        chk("left_pos_wrapped", bus.pos, 0);
        chk("left_wrap_pulse", bus.wrap, 1);
      end
    end
    chk("left_wrap_count", nwrap, 1);

    // Scroll right from pos 0
    bus.dir = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      step_clk();
      if (c == 4) begin
        chk("right_pos7", bus.pos, 7);
        chk("right_wrap", bus.wrap, 1);
      end
      if (c == 5) begin
        chk("right_hex", bus.hex, hx(S_BL, S_D, S_E, S_1));
        chk("right_wrap_one_cycle", bus.wrap, 0);
      end
    end

    // Pause holds position
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
    changed = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step_clk();
      if (bus.pos !== 3'd7) changed = 1'b1;
    end
    chk("pause_pos_changed", changed, 0);

    // Single manual step wraps 7 -> 0
    bus.step = 1'b1;
    step_clk();
    chk("step_pos", bus.pos, 0);
    chk("step_wrap", bus.wrap, 1);
    bus.step = 1'b0;
    step_clk();
    chk("step_hex", bus.hex, hx(S_D, S_E, S_1, S_0));

    // step is ignored while running
    bus.run = 1'b1; bus.step = 1'b1;
    step_clk();
    step_clk();
    chk("step_ignored_run", bus.pos, 0);
    bus.run = 1'b0; bus.step = 1'b0;
    step_clk();

    // Write and advance on the same edge
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd1, 5'h11);
    step_clk();
    chk("wr_adv_pos", bus.pos, 1);
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
    step_clk();
    chk("wr_adv_hex", bus.hex, hx(S_MI, S_1, S_0, S_BL));

    // Reset at pos 3
    bus.step = 1'b1; step_clk();
    bus.step = 1'b0; step_clk();
    bus.step = 1'b1; step_clk();
    bus.step = 1'b0;
    chk("pre_rst_pos3", bus.pos, 3);
    rst = 1'b1;
    step_clk();
    chk("rst_pos", bus.pos, 0);
    chk("rst_hex", bus.hex, H_ALL);
    chk("rst_wrap", bus.wrap, 0);
    rst = 1'b0;
    step_clk();
    chk("post_rst_msg_gone", bus.hex, H_ALL);

    // Randomized traffic against the model
    for (int c = 0; c < 800; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 15) == 0) bus.run = ~bus.run;
      if ($urandom_range(0, 7) == 0)  bus.dir = ~bus.dir;
      bus.step    = ($urandom_range(0, 3) == 0);
      bus.wr_en   = ($urandom_range(0, 2) == 0);
      bus.wr_addr = 5'($urandom_range(0, 15));
      bus.wr_data = 5'($urandom_range(0, 31));
      step_clk();
      chk($sformatf("rnd%0d_pos", c), bus.pos, 64'(m_pos));
      chk($sformatf("rnd%0d_wrap", c), bus.wrap, m_wrap);
      chk($sformatf("rnd%0d_hex", c), bus.hex, m_hex);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
